// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative unsigned multiply/divide unit with HI/LO result
// registers. MULTU uses shift-add, DIVU uses restoring division; both take
// exactly WIDTH cycles. MTHI/MTLO write HI/LO directly in one cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   x_q, y_q;
  // Shared working register: product {upper, multiplier} for MUL,
  // {partial remainder, dividend/quotient} for DIV.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dbz_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_d;
  logic [WIDTH:0]     div_part;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_d;

  // One datapath step for each algorithm, computed from the current working register.
  always_comb begin
    // Shift-add: conditionally add multiplicand to upper half, then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, x_q} : '0);
    mul_d    = {mul_sum, acc_q[WIDTH-1:1]};
    // Restoring divide: shift next dividend bit into the remainder and trial-subtract.
    div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_part >= {1'b0, y_q});
    // The difference is always below the divisor when taken, so it fits in WIDTH bits.
    div_rem  = div_part[WIDTH-1:0] - y_q;
    div_d    = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                      : {acc_q[2*WIDTH-2:0], 1'b0};
  end

  // Control FSM with registered status outputs and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (start) begin
            x_q   <= x;
            y_q   <= y;
            cnt_q <= '0;
            case (op)
              OP_MULTU: begin
                acc_q   <= {{WIDTH{1'b0}}, y};
                state_q <= S_MUL;
                busy_q  <= 1'b1;
              end
              OP_DIVU: begin
                if (y == '0) begin
                  // Divide by zero completes immediately with a defined result.
                  hi_q    <= x;
                  lo_q    <= '1;
                  done_q  <= 1'b1;
                  dbz_q   <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  acc_q   <= {{WIDTH{1'b0}}, x};
                  state_q <= S_DIV;
                  busy_q  <= 1'b1;
                end
              end
              OP_MTHI: hi_q <= x;
              OP_MTLO: lo_q <= x;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_q <= mul_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            hi_q    <= mul_d[2*WIDTH-1:WIDTH];
            lo_q    <= mul_d[WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DIV: begin
          acc_q <= div_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            hi_q    <= div_d[2*WIDTH-1:WIDTH];
            lo_q    <= div_d[WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed scenarios plus randomized operations,
// with a queue-based scoreboard checked by an independent done monitor.
module tb_muldiv_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  x = '0, y = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] hi_m = '0, lo_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (div_by_zero && !done) chk("dbz_without_done", 64'(div_by_zero), 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("op done: hi=0x%08h lo=0x%08h dbz=%0d cycle=%0d", hi, lo, div_by_zero, cyc);
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Drive a request at the current negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    x     = a;
    y     = b;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    x     = $urandom;
    y     = $urandom;
  endtask

  // Run one operation through the reference model and wait for it to complete.
  // pulse_at > 0 injects a stray start request at that busy cycle.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int pulse_at);
    exp_t        e;
    logic [63:0] p;
    int          bc;
    bit          held;
    e.cyc = cyc + 1;
    e.dbz = 1'b0;
    e.hi  = hi_m;
    e.lo  = lo_m;
    if (o == 2'b00) begin
      p     = 64'(a) * 64'(b);
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.cyc = e.cyc + W;
    end else if (o == 2'b01) begin
      if (b == '0) begin
        e.hi  = a;
        e.lo  = '1;
        e.dbz = 1'b1;
      end else begin
        e.hi  = a % b;
        e.lo  = a / b;
        e.cyc = e.cyc + W;
      end
    end
    if (o < 2'b10) exp_q.push_back(e);
    $display("issue op=%0d x=0x%08h y=0x%08h cycle=%0d", o, a, b, cyc);
    issue(o, a, b);
    if (o >= 2'b10) begin
      if (o == 2'b10) hi_m = a;
      else            lo_m = a;
      chk("mt_hi", 64'(hi), 64'(hi_m));
      chk("mt_lo", 64'(lo), 64'(lo_m));
      chk("mt_busy_done", {62'd0, busy, done}, 64'd0);
      return;
    end
    bc   = 0;
    held = 1'b1;
    for (int n = 0; n < W + 4 && !done; n++) begin
      if (busy) bc++;
      if (hi !== hi_m || lo !== lo_m) held = 1'b0;
      start = (pulse_at > 0 && bc == pulse_at);
      op    = 2'($urandom);
      x     = $urandom;
      y     = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    if (!done && exp_q.size() > 0) void'(exp_q.pop_back());
    chk("busy_cycles", 64'(bc), e.dbz ? 64'd0 : 64'(W));
    chk("hold_during_busy", 64'(held), 64'd1);
    hi_m = e.hi;
    lo_m = e.lo;
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {59'd0, busy, done, div_by_zero, |hi, |lo}, 64'd0);
    rst_n = 1'b1;

    // Directed scenarios
    do_op(2'b00, 32'd6, 32'd7, 0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'b01, 32'd100, 32'd7, 0);              // back-to-back from DONE
    do_op(2'b01, 32'h1234_5678, 32'd0, 0);
    do_op(2'b10, 32'hDEAD_BEEF, 32'd0, 0);
    do_op(2'b11, 32'h1, 32'd0, 0);
    @(negedge clk);
    chk("mt_no_done", {62'd0, busy, done}, 64'd0);

    // Abort: stray MTLO at busy cycle 5, reset at busy cycle 10
    $display("issue op=0 x=0x00001234 y=0x00005678 (to be aborted) cycle=%0d", cyc);
    exp_q.push_back('{hi: '0, lo: '0, dbz: 1'b0, cyc: cyc + 1 + W});
    issue(2'b00, 32'h1234, 32'h5678);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; x = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    chk("stray_mtlo_ignored", 64'(lo), 64'(lo_m));
    rst_n = 1'b0;
    @(negedge clk);
    void'(exp_q.pop_back());
    hi_m = '0;
    lo_m = '0;
    $display("reset abort cycle=%0d busy=%0d hi=0x%08h lo=0x%08h", cyc, busy, hi, lo);
    chk("abort_state", {59'd0, busy, done, div_by_zero, |hi, |lo}, 64'd0);
    rst_n = 1'b1;
    do_op(2'b10, 32'h0BAD_CAFE, 32'd0, 0);        // accepted on first edge out of reset
    repeat (W + 4) @(negedge clk);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 50));
      do_op(ro, ra, rb, int'($urandom_range(0, W - 2)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, the operation request, sampled only when busy=0.
REQ-005 The block SHALL have port op, input, 2, the operation select: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 The block SHALL have port x, input, WIDTH, operand A (dividend, multiplicand, or MTHI/MTLO data).
REQ-007 The block SHALL have port y, input, WIDTH, operand B (divisor, multiplier).
REQ-008 The block SHALL have port busy, output, 1, high while an iterative operation is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking that a MULTU/DIVU result is valid.
REQ-010 The block SHALL have port div_by_zero, output, 1, valid with done; high if the completed DIVU had y=0.
REQ-011 The block SHALL have port hi, output, WIDTH, the HI register: product upper half or remainder.
REQ-012 The block SHALL have port lo, output, WIDTH, the LO register: product lower half or quotient.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, MUL, DIV and DONE; busy=1 exactly in MUL and DIV.
REQ-014 In IDLE or DONE with start=1, the block SHALL latch x and y and take the transition selected by op:
- MULTU -> MUL
- DIVU with y!=0 -> DIV
- DIVU with y=0 -> DONE
- MTHI/MTLO -> IDLE
REQ-015 With start=0, the block SHALL go from DONE to IDLE and hold IDLE.
REQ-016 MULTU SHALL be an unsigned shift-add multiply: one multiplier bit per cycle, exactly WIDTH cycles in MUL, then DONE.
REQ-017 DIVU SHALL be an unsigned restoring divide: one quotient bit per cycle, exactly WIDTH cycles in DIV, then DONE.
REQ-018 An iteration counter of ceil(log2(WIDTH))+1 bits SHALL count the cycles; the last iteration is at count WIDTH-1, with no wrap into an extra cycle.
REQ-019 Latency: if start is accepted at edge k, busy SHALL be 1 for cycles k+1..k+WIDTH, and done=1 with the new hi/lo at cycle k+WIDTH+1.
REQ-020 hi and lo SHALL hold their previous values throughout MUL/DIV and update only on the edge entering DONE; intermediate values SHALL never be visible.
REQ-021 MULTU result: {hi,lo} SHALL equal the full 2*WIDTH-bit unsigned product x*y.
REQ-022 DIVU result: lo SHALL equal x/y and hi SHALL equal x%y, both unsigned.
REQ-023 DIVU with y=0 SHALL skip iteration: DONE at cycle k+1, lo=all ones, hi=x, div_by_zero=1.
REQ-024 div_by_zero SHALL be 0 in every cycle where done=0, and 0 with the done of a MULTU or of a DIVU with y!=0.
REQ-025 MTHI/MTLO SHALL write x into hi or lo on the accepting edge, leave the other register unchanged, and raise neither busy nor done.
REQ-026 start while busy=1 SHALL be ignored with no effect on state, operands or outputs; it is not queued.
REQ-027 start in DONE SHALL be accepted as in IDLE, allowing back-to-back operations with no idle cycle.
REQ-028 Changes on x, y or op after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE and set busy=0, done=0, div_by_zero=0, hi=0, lo=0, and counter and operand registers to 0.
REQ-030 Reset SHALL take priority over start and SHALL abort any MUL/DIV in progress; no done is produced for the aborted operation.
REQ-031 start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-032 MULTU x=6, y=7 -> busy high 32 cycles, then done=1 with hi=0x00000000, lo=0x0000002A.
REQ-033 MULTU x=0xFFFFFFFF, y=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; back-to-back DIVU x=100, y=7 started in the DONE cycle -> lo=14, hi=2 after 32 busy cycles.
REQ-034 DIVU x=0x12345678, y=0 -> done one cycle after start, lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1.
REQ-035 MTHI x=0xDEADBEEF, then MTLO x=0x1 -> hi=0xDEADBEEF, lo=0x1, busy and done stay 0.
REQ-036 MULTU started, start pulsed with op=MTLO at busy cycle 5, then rst_n=0 at busy cycle 10 -> the MTLO is ignored, and the cycle after the reset edge shows busy=0, hi=lo=0, with no done pulse.
